vj_feature_sum: RTL and testbench
=================================

// Module: vj_feature_sum
// PURPOSE
//  Next-gen rectangle-sum engine for the Viola-Jones detector: evaluates a full Haar feature of up to
//  MAX_RECTS weighted rectangles relative to a detection-window origin, in one start/done transaction.
//  Corner reads stream one per cycle to the integral-image RAM with a parametrised read latency; the
//  weighted signed sum goes to the classifier stage. Out-of-window rectangles are flagged, not read.
// PARAMETERS
//  II_W       321  integral-image row pitch (pixels + 1 zero border column)
//  II_H       241  integral-image rows (incl. zero border row)
//  ADDR_W     17   ii_raddr width; must hold II_W*II_H-1
//  II_DATA_W  32   integral-image word width (unsigned)
//  RD_LAT     1    RAM read latency in cycles (>=1); rdata for raddr of cycle t valid in cycle t+RD_LAT
//  MAX_RECTS  3    max rectangles per feature (>=1)
//  WEIGHT_W   8    signed per-rectangle weight width
//  derived (localparam): X_W=$clog2(II_W), Y_W=$clog2(II_H), N_W=$clog2(MAX_RECTS+1),
//           SUM_W=II_DATA_W+WEIGHT_W+1+$clog2(MAX_RECTS)
// PORTS
//  clk        in   1                 clock; single clock domain
//  reset      in   1                 synchronous, active-high reset
//  start      in   1                 request; accepted only when busy==0
//  win_x      in   X_W               window origin x (added to every rect x)
//  win_y      in   Y_W               window origin y
//  n_rects    in   N_W               active rectangles, 0..MAX_RECTS; entries >= n_rects ignored
//  rect_x     in   MAX_RECTS*X_W     rect i at [i*X_W +: X_W]; likewise rect_y/rect_w/rect_h/rect_wt
//  rect_y     in   MAX_RECTS*Y_W     rect y offsets
//  rect_w     in   MAX_RECTS*X_W     rect widths
//  rect_h     in   MAX_RECTS*Y_W     rect heights
//  rect_wt    in   MAX_RECTS*WEIGHT_W signed weights
//  ii_raddr   out  ADDR_W            registered RAM read address
//  ii_rdata   in   II_DATA_W         RAM read data
//  busy       out  1                 high from cycle after accepted start through done cycle
//  done       out  1                 one-cycle pulse; sum/err valid from this cycle until next accepted start
//  err        out  1                 some active rect had x1>=II_W or y1>=II_H
//  sum        out  SUM_W signed      sum_i wt_i*(D-B-C+A)
// BEHAVIOUR
//  - Reset (sync, highest priority, also mid-transaction): state IDLE, busy=0, done=0, err=0, sum=0,
//    ii_raddr=0, accumulator and tag pipe cleared; in-flight RAM data discarded.
//  - All inputs sampled only in the start-accept cycle (cycle 0); internal copies used afterwards.
//  - Corners rect i: x0=win_x+rect_x, y0=win_y+rect_y, x1=x0+rect_w, y1=y0+rect_h, computed at X_W+1/Y_W+1
//    bits (no wrap). Address = y*II_W + x. Order per rect A(x0,y0)+, B(x1,y0)-, C(x0,y1)-, D(x1,y1)+.
//  - FSM IDLE -> ISSUE -> DRAIN -> IDLE; ERR path IDLE -> IDLE with done.
//    IDLE: on start: if n_rects==0 -> done=1,sum=0,err=0 in cycle 1; else if any active rect out of bounds
//      -> done=1,err=1,sum=0 in cycle 1, no RAM reads; else busy=1, acc=0, go ISSUE.
//    ISSUE: corner k (0..4N-1, rect k/4, corner k%4) drives ii_raddr in cycle 1+k, back-to-back;
//      after k=4N-1 -> DRAIN.
//    DRAIN: wait for tagged returns; corner k data consumed in cycle 1+k+RD_LAT: acc += sign*wt*rdata.
//      last corner: sum <= acc+term, done=1 in cycle 4N+RD_LAT+1, busy drops same cycle -> IDLE.
//  - Latency start->done = 4N+RD_LAT+1 cycles (N=1,RD_LAT=1: 6). Next start accepted in done cycle+1.
//  - start while busy==1 ignored (no queueing). done never asserted without a preceding accepted start.
//  - Arithmetic: rdata zero-extended, weight sign-extended; acc SUM_W+2 bits signed, sum = acc truncated
//    to SUM_W (exact for valid integral images). n_rects>MAX_RECTS clamped to MAX_RECTS.
//  - x1==II_W-1 / y1==II_H-1 legal (last row/col); zero w or h legal (rect contributes 0).
// STRUCTURE
//  - Package vj_pkg: state enum (IDLE/ISSUE/DRAIN), corner sign constants, function ii_addr(x,y,II_W).
//  - Sub-module vj_rd_tag_pipe #(RD_LAT,TAG_W): RD_LAT-deep shift register carrying {valid,sign,rect idx,last}
//    aligned with RAM returns; synchronous reset clears valid bits.
//  - Top: bounds-check (MAX_RECTS comparators on start), issue counter, MAC/accumulator, output regs.
// TESTING
//  - 1 rect, win=(0,0), rect (2,3,4,5) wt=+1, ramp II model RD_LAT=1 -> ii_raddr 965,969,2570,2574 in
//    cycles 1-4; done cycle 6, sum=D-B-C+A.
//  - 2-rect edge feature, wt -1/+2, all-ones image (II(x,y)=x*y), RD_LAT=3 -> sum=-20+2*20=20, done cycle 12.
//  - Bounds: win_x=318, rect_w=5 -> done cycle 1, err=1, sum=0, no ii_raddr change; n_rects=0 -> done
//    cycle 1, err=0, sum=0.
//  - start pulsed during busy and held after done -> first ignored, second accepted cycle after done.
//  - reset asserted in DRAIN with RD_LAT=4 -> next cycle busy=0,done=0,sum=0; no spurious done later;
//    following transaction correct.
//  - Random: MAX_RECTS=3, random weights/rects/window vs reference model, RD_LAT in {1,2,5}, 10k features.

Source files
------------

// File: rtl/vj_pkg.sv
// Shared types and helpers for the Viola-Jones Haar feature summation engine.
package vj_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    // Corners are issued in the order A, B, C, D. A set bit marks a subtracted corner (B and C).
    localparam logic [3:0] CORNER_NEG = 4'b0110;

    // Linear integral-image address of point (x, y) for a given row pitch.
    function automatic logic [31:0] ii_addr(input logic [15:0] x, input logic [15:0] y,
                                            input int unsigned pitch);
        return 32'(y) * pitch + 32'(x);
    endfunction

endpackage

// File: rtl/vj_rd_tag_pipe.sv
// Delay line that carries a corner descriptor alongside the RAM read, so that each
// descriptor arrives in the same cycle as the data word it describes.
module vj_rd_tag_pipe #(
    parameter int RD_LAT = 1,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [TAG_W-1:0] tag_in,
    output logic [TAG_W-1:0] tag_out
);

    logic [TAG_W-1:0] pipe_d [RD_LAT];
    logic [TAG_W-1:0] pipe_q [RD_LAT];

    // Shift every stage forward by one, feeding the newest descriptor into stage 0.
    always_comb begin
        pipe_d[0] = tag_in;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipeline registers; reset drops every in-flight descriptor so stale reads are never consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tag_out = pipe_q[RD_LAT-1];

endmodule

// File: rtl/vj_feature_sum.sv
// Haar feature evaluator: bounds-checks the rectangles of a feature, streams four corner
// reads per rectangle to the integral-image RAM and accumulates the weighted signed sum.
module vj_feature_sum
    import vj_pkg::*;
#(
    parameter int II_W      = 321,
    parameter int II_H      = 241,
    parameter int ADDR_W    = 17,
    parameter int II_DATA_W = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_RECTS = 3,
    parameter int WEIGHT_W  = 8,
    localparam int X_W      = $clog2(II_W),
    localparam int Y_W      = $clog2(II_H),
    localparam int N_W      = $clog2(MAX_RECTS + 1),
    localparam int SUM_W    = II_DATA_W + WEIGHT_W + 1 + $clog2(MAX_RECTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [X_W-1:0]                win_x,
    input  logic [Y_W-1:0]                win_y,
    input  logic [N_W-1:0]                n_rects,
    input  logic [MAX_RECTS*X_W-1:0]      rect_x,
    input  logic [MAX_RECTS*Y_W-1:0]      rect_y,
    input  logic [MAX_RECTS*X_W-1:0]      rect_w,
    input  logic [MAX_RECTS*Y_W-1:0]      rect_h,
    input  logic [MAX_RECTS*WEIGHT_W-1:0] rect_wt,
    output logic [ADDR_W-1:0]             ii_raddr,
    input  logic [II_DATA_W-1:0]          ii_rdata,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic signed [SUM_W-1:0]       sum
);

    localparam int ACC_W = SUM_W + 2;
    localparam int XE_W  = X_W + 2;
    localparam int YE_W  = Y_W + 2;
    localparam int R_W   = (MAX_RECTS > 1) ? $clog2(MAX_RECTS) : 1;
    localparam int C_W   = $clog2(4 * MAX_RECTS);
    localparam int TAG_W = 3 + R_W;

    state_e state_q, state_d;
    logic [C_W-1:0]    cnt_q, cnt_d;
    logic [C_W-1:0]    last_q, last_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic err_q, err_d;
    logic done_q, done_d;

    logic [X_W-1:0] x0_q [MAX_RECTS];
    logic [X_W-1:0] x0_d [MAX_RECTS];
    logic [X_W-1:0] x1_q [MAX_RECTS];
    logic [X_W-1:0] x1_d [MAX_RECTS];
    logic [Y_W-1:0] y0_q [MAX_RECTS];
    logic [Y_W-1:0] y0_d [MAX_RECTS];
    logic [Y_W-1:0] y1_q [MAX_RECTS];
    logic [Y_W-1:0] y1_d [MAX_RECTS];
    logic signed [WEIGHT_W-1:0] wt_q [MAX_RECTS];
    logic signed [WEIGHT_W-1:0] wt_d [MAX_RECTS];

    logic [XE_W-1:0] in_x0 [MAX_RECTS];
    logic [XE_W-1:0] in_x1 [MAX_RECTS];
    logic [YE_W-1:0] in_y0 [MAX_RECTS];
    logic [YE_W-1:0] in_y1 [MAX_RECTS];
    logic [N_W-1:0]  n_eff;
    logic            oob;

    logic [C_W-1:0] nxt_k;
    logic [R_W-1:0] nxt_r;
    logic [1:0]     nxt_c;
    logic [X_W-1:0] nxt_x;
    logic [Y_W-1:0] nxt_y;

    logic [TAG_W-1:0] tag_in;
    logic [TAG_W-1:0] tag_out;
    logic             t_valid;
    logic             t_neg;
    logic [R_W-1:0]   t_rect;
    logic             t_last;

    logic signed [ACC_W-1:0] data_ext;
    logic signed [ACC_W-1:0] wt_ext;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] acc_sum;

    // Absolute corners straight from the ports, widened so the bounds compare never wraps.
    always_comb begin
        n_eff = (int'(n_rects) > MAX_RECTS) ? N_W'(MAX_RECTS) : n_rects;
        oob   = 1'b0;
        for (int i = 0; i < MAX_RECTS; i++) begin
            in_x0[i] = XE_W'(win_x) + XE_W'(rect_x[i*X_W +: X_W]);
            in_x1[i] = in_x0[i] + XE_W'(rect_w[i*X_W +: X_W]);
            in_y0[i] = YE_W'(win_y) + YE_W'(rect_y[i*Y_W +: Y_W]);
            in_y1[i] = in_y0[i] + YE_W'(rect_h[i*Y_W +: Y_W]);
            if ((i < int'(n_eff)) &&
                ((in_x1[i] >= XE_W'(II_W)) || (in_y1[i] >= YE_W'(II_H)))) begin
                oob = 1'b1;
            end
        end
    end

    // Address of the corner that follows the one currently on the RAM port.
    always_comb begin
        nxt_k = cnt_q + C_W'(1);
        nxt_r = R_W'(nxt_k >> 2);
        nxt_c = nxt_k[1:0];
        nxt_x = nxt_c[0] ? x1_q[nxt_r] : x0_q[nxt_r];
        nxt_y = nxt_c[1] ? y1_q[nxt_r] : y0_q[nxt_r];
    end

    // Descriptor for the read presented this cycle, and unpacking of the one returning now.
    always_comb begin
        tag_in  = {state_q == ISSUE, CORNER_NEG[cnt_q[1:0]], R_W'(cnt_q >> 2), cnt_q == last_q};
        t_valid = tag_out[TAG_W-1];
        t_neg   = tag_out[TAG_W-2];
        t_rect  = tag_out[1 +: R_W];
        t_last  = tag_out[0];
    end

    vj_rd_tag_pipe #(
        .RD_LAT (RD_LAT),
        .TAG_W  (TAG_W)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Weighted contribution of the returning corner: data zero-extended, weight sign-extended.
    always_comb begin
        data_ext = ACC_W'(ii_rdata);
        wt_ext   = ACC_W'(wt_q[t_rect]);
        prod     = data_ext * wt_ext;
        acc_sum  = t_neg ? (acc_q - prod) : (acc_q + prod);
    end

    // Control FSM, rectangle capture and accumulation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        raddr_d = raddr_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        err_d   = err_q;
        done_d  = 1'b0;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        wt_d    = wt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_eff == '0) begin
                        done_d = 1'b1;
                        err_d  = 1'b0;
                        sum_d  = '0;
                    end else if (oob) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                        sum_d  = '0;
                    end else begin
                        state_d = ISSUE;
                        cnt_d   = '0;
                        last_d  = C_W'(int'(n_eff) * 4 - 1);
                        acc_d   = '0;
                        raddr_d = ADDR_W'(ii_addr(16'(in_x0[0]), 16'(in_y0[0]), II_W));
                        for (int i = 0; i < MAX_RECTS; i++) begin
                            x0_d[i] = X_W'(in_x0[i]);
                            x1_d[i] = X_W'(in_x1[i]);
                            y0_d[i] = Y_W'(in_y0[i]);
                            y1_d[i] = Y_W'(in_y1[i]);
                            wt_d[i] = rect_wt[i*WEIGHT_W +: WEIGHT_W];
                        end
                    end
                end
            end
            ISSUE: begin
                if (cnt_q == last_q) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d   = nxt_k;
                    raddr_d = ADDR_W'(ii_addr(16'(nxt_x), 16'(nxt_y), II_W));
                end
            end
            DRAIN: begin
                if (done_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (t_valid) begin
            acc_d = acc_sum;
            if (t_last) begin
                sum_d  = SUM_W'(acc_sum);
                err_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Control and result registers; reset wins over everything, including a running feature.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            raddr_q <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            raddr_q <= raddr_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Captured rectangle corners and weights; only read back while a feature is running.
    always_ff @(posedge clk) begin
        x0_q <= x0_d;
        x1_q <= x1_d;
        y0_q <= y0_d;
        y1_q <= y1_d;
        wt_q <= wt_d;
    end

    assign ii_raddr = raddr_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign sum      = sum_q;

endmodule

// File: tb/tb_vj_feature_sum.sv
// Directed bench for vj_feature_sum: two instances (read latency 1 and 4) share stimulus,
// each with its own integral-image RAM model.
module tb_vj_feature_sum;

    localparam int II_W      = 321;
    localparam int MAX_RECTS = 3;
    localparam int WEIGHT_W  = 8;
    localparam int X_W       = 9;
    localparam int Y_W       = 8;
    localparam int N_W       = 2;
    localparam int SUM_W     = 43;

    logic clk;
    logic reset;
    logic start;
    logic [X_W-1:0] win_x;
    logic [Y_W-1:0] win_y;
    logic [N_W-1:0] n_rects;
    logic [MAX_RECTS*X_W-1:0] rect_x;
    logic [MAX_RECTS*Y_W-1:0] rect_y;
    logic [MAX_RECTS*X_W-1:0] rect_w;
    logic [MAX_RECTS*Y_W-1:0] rect_h;
    logic [MAX_RECTS*WEIGHT_W-1:0] rect_wt;

    logic [16:0] raddr1, raddr4;
    logic [31:0] rdata1, rdata4;
    logic busy1, busy4, done1, done4, err1, err4;
    logic signed [SUM_W-1:0] sum1, sum4;

    logic [31:0] pipe4 [4];
    int img_mode;
    logic [16:0] addr_seen [1:4];
    int total_checks;
    int pass_count;

    vj_feature_sum #(.RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .win_x(win_x), .win_y(win_y),
        .n_rects(n_rects), .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w),
        .rect_h(rect_h), .rect_wt(rect_wt), .ii_raddr(raddr1), .ii_rdata(rdata1),
        .busy(busy1), .done(done1), .err(err1), .sum(sum1)
    );

    vj_feature_sum #(.RD_LAT(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start), .win_x(win_x), .win_y(win_y),
        .n_rects(n_rects), .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w),
        .rect_h(rect_h), .rect_wt(rect_wt), .ii_raddr(raddr4), .ii_rdata(rdata4),
        .busy(busy4), .done(done4), .err(err4), .sum(sum4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Integral image: mode 0 is an all-ones image (x*y), mode 1 a ramp (x*x*y).
    function automatic logic [31:0] ii_val(input logic [16:0] a, input int mode);
        int unsigned x, y;
        x = int'(a) % II_W;
        y = int'(a) / II_W;
        return (mode == 0) ? 32'(x * y) : 32'(x * x * y);
    endfunction

    // RAM models with read latency 1 and 4.
    always @(posedge clk) begin
        rdata1   <= ii_val(raddr1, img_mode);
        pipe4[0] <= ii_val(raddr4, img_mode);
        pipe4[1] <= pipe4[0];
        pipe4[2] <= pipe4[1];
        pipe4[3] <= pipe4[2];
    end
    assign rdata4 = pipe4[3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total_checks++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, $signed(observed), $signed(expected));
    endtask

    task automatic applyStimulus(input int wx, input int wy, input int n);
        win_x   = X_W'(wx);
        win_y   = Y_W'(wy);
        n_rects = N_W'(n);
    endtask

    task automatic setRect(input int i, input int x, input int y, input int w, input int h,
                           input int wt);
        rect_x[i*X_W +: X_W]           = X_W'(x);
        rect_y[i*Y_W +: Y_W]           = Y_W'(y);
        rect_w[i*X_W +: X_W]           = X_W'(w);
        rect_h[i*Y_W +: Y_W]           = Y_W'(h);
        rect_wt[i*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(wt);
    endtask

    // One start pulse, then 22 cycles checking done timing and results of both instances.
    task automatic runFeature(input string tag, input int d1, input int d4,
                              input longint exp_sum, input logic exp_err);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            if (c <= 4) addr_seen[c] = raddr1;
            checkOutput({tag, "_done1"}, 64'(done1), 64'(c == d1));
            checkOutput({tag, "_done4"}, 64'(done4), 64'(c == d4));
            if (c == d1) begin
                checkOutput({tag, "_sum1"}, 64'(sum1), 64'(exp_sum));
                checkOutput({tag, "_err1"}, 64'(err1), 64'(exp_err));
                checkOutput({tag, "_busy1"}, 64'(busy1), 64'(d1 != 1));
            end
            if (c == d4) begin
                checkOutput({tag, "_sum4"}, 64'(sum4), 64'(exp_sum));
                checkOutput({tag, "_err4"}, 64'(err4), 64'(exp_err));
            end
            tick();
        end
    endtask

    initial begin
        total_checks = 0;
        pass_count   = 0;
        img_mode     = 1;
        reset        = 1'b1;
        start        = 1'b0;
        rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0; rect_wt = '0;
        applyStimulus(0, 0, 0);
        tick(); tick(); tick();
        checkOutput("rst_busy1", 64'(busy1), 64'(0));
        checkOutput("rst_done1", 64'(done1), 64'(0));
        checkOutput("rst_err1", 64'(err1), 64'(0));
        checkOutput("rst_sum1", 64'(sum1), 64'(0));
        checkOutput("rst_raddr1", 64'(raddr1), 64'(0));
        checkOutput("rst_busy4", 64'(busy4), 64'(0));
        reset = 1'b0;
        tick();

        // Single rectangle on the ramp image: D-B-C+A = 288-108-32+12.
        img_mode = 1;
        applyStimulus(0, 0, 1);
        setRect(0, 2, 3, 4, 5, 1);
        runFeature("t1", 6, 9, 160, 1'b0);
        checkOutput("t1_addrA", 64'(addr_seen[1]), 64'(965));
        checkOutput("t1_addrB", 64'(addr_seen[2]), 64'(969));
        checkOutput("t1_addrC", 64'(addr_seen[3]), 64'(2570));
        checkOutput("t1_addrD", 64'(addr_seen[4]), 64'(2574));

        // Two-rectangle edge feature on the all-ones image: -1*20 + 2*20.
        img_mode = 0;
        applyStimulus(10, 10, 2);
        setRect(0, 0, 0, 4, 5, -1);
        setRect(1, 4, 0, 4, 5, 2);
        runFeature("t2", 10, 13, 20, 1'b0);

        // x1 = 323 is past the last column: immediate error, RAM address untouched.
        applyStimulus(318, 0, 1);
        setRect(0, 0, 0, 5, 1, 1);
        runFeature("t3", 1, 1, 0, 1'b1);
        checkOutput("t3_raddr_hold", 64'(addr_seen[1]), 64'(4833));

        // No active rectangles: immediate done, error cleared.
        applyStimulus(0, 0, 0);
        runFeature("t4", 1, 1, 0, 1'b0);

        // Rectangle touching the last column and row is legal.
        applyStimulus(316, 235, 1);
        setRect(0, 0, 0, 4, 5, 1);
        runFeature("t5", 6, 9, 20, 1'b0);
        checkOutput("t5_addrA", 64'(addr_seen[1]), 64'(75751));
        checkOutput("t5_addrD", 64'(addr_seen[4]), 64'(77360));

        // Zero-width rectangle contributes nothing; inactive third entry is out of bounds but ignored.
        applyStimulus(0, 0, 2);
        setRect(0, 5, 5, 0, 3, 7);
        setRect(1, 1, 1, 2, 2, -3);
        setRect(2, 300, 0, 100, 1, 1);
        runFeature("t6", 10, 13, -12, 1'b0);

        // Three rectangles on the ramp image: -128*168 - 184 + 3*200.
        img_mode = 1;
        applyStimulus(20, 30, 3);
        setRect(0, 0, 0, 2, 2, -128);
        setRect(1, 2, 0, 2, 2, -1);
        setRect(2, 4, 0, 2, 2, 3);
        runFeature("t7", 14, 17, -21088, 1'b0);

        // Start pulsed while busy is ignored; start held from the done cycle is taken one cycle later.
        img_mode = 0;
        for (int c = 0; c <= 24; c++) begin
            if (c == 0) begin
                applyStimulus(0, 0, 1);
                setRect(0, 0, 0, 2, 2, 1);
            end
            if (c == 3) applyStimulus(0, 0, 0);
            if (c == 6) begin
                applyStimulus(0, 0, 1);
                setRect(0, 0, 0, 1, 1, 5);
            end
            start = (c == 0) || (c == 3) || (c >= 6 && c <= 10);
            tick();
            checkOutput("hold_done1", 64'(done1), 64'((c + 1 == 6) || (c + 1 == 13)));
            checkOutput("hold_done4", 64'(done4), 64'((c + 1 == 9) || (c + 1 == 19)));
            if (c + 1 == 6)  checkOutput("hold_sum1_a", 64'(sum1), 64'(4));
            if (c + 1 == 13) checkOutput("hold_sum1_b", 64'(sum1), 64'(5));
            if (c + 1 == 9)  checkOutput("hold_sum4_a", 64'(sum4), 64'(4));
            if (c + 1 == 19) checkOutput("hold_sum4_b", 64'(sum4), 64'(5));
        end
        start = 1'b0;

        // Reset while the latency-4 instance is draining.
        applyStimulus(0, 0, 1);
        setRect(0, 0, 0, 2, 2, 1);
        for (int c = 0; c <= 6; c++) begin
            start = (c == 0);
            reset = (c == 6);
            tick();
            if (c + 1 == 6) begin
                checkOutput("pre_rst_done1", 64'(done1), 64'(1));
                checkOutput("pre_rst_busy4", 64'(busy4), 64'(1));
                checkOutput("pre_rst_sum4", 64'(sum4), 64'(5));
            end
        end
        reset = 1'b0;
        checkOutput("mid_rst_busy4", 64'(busy4), 64'(0));
        checkOutput("mid_rst_done4", 64'(done4), 64'(0));
        checkOutput("mid_rst_sum4", 64'(sum4), 64'(0));
        checkOutput("mid_rst_raddr4", 64'(raddr4), 64'(0));
        checkOutput("mid_rst_sum1", 64'(sum1), 64'(0));
        checkOutput("mid_rst_busy1", 64'(busy1), 64'(0));
        for (int c = 0; c < 15; c++) begin
            tick();
            checkOutput("post_rst_done1", 64'(done1), 64'(0));
            checkOutput("post_rst_done4", 64'(done4), 64'(0));
        end

        // Transaction after reset behaves normally.
        img_mode = 1;
        applyStimulus(0, 0, 1);
        setRect(0, 2, 3, 4, 5, 1);
        runFeature("t8", 6, 9, 160, 1'b0);
        checkOutput("t8_addrA", 64'(addr_seen[1]), 64'(965));

        $display("%0d/%0d checks passed", pass_count, total_checks);
        $finish;
    end

endmodule
